layer_serializer: RTL
=====================

Name: layer_serializer

Overview:
- Parallel-to-serial converter between two linear layers of the MNIST accelerator.
- Captures the full NUM_NODES-wide output vector of one layer on a valid pulse.
- Streams the vector one element per handshake into the serial din/i_valid input of the next layer.
- Holds one pending vector so a new layer result can land while the previous vector is still streaming.

Parameters:
- DATA_WIDTH, 24, element width in bits, signed two's complement.
- NUM_NODES, 20, elements per captured vector; minimum 2.
- IDX_WIDTH, $clog2(NUM_NODES), width of the element index output.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_valid  input  1  single-cycle pulse: din_vec holds a complete layer result.
- din_vec  input  DATA_WIDTH x NUM_NODES  unpacked array of parallel layer outputs.
- i_ready  output  1  high when a vector presented on i_valid will be accepted.
- o_valid  output  1  o_data holds a valid element.
- o_ready  input  1  downstream accepts the element on o_valid && o_ready.
- o_data  output  DATA_WIDTH  current element.
- o_index  output  IDX_WIDTH  index of the current element, 0..NUM_NODES-1.
- o_last  output  1  high with o_valid when o_index == NUM_NODES-1.
- o_overflow  output  1  sticky: a vector arrived while i_ready was low.

Behaviour:
- Storage:
  - active buffer + active_vld flag.
  - pending buffer + pend_vld flag.
  - element counter idx.
- Reset (rst low, asynchronous):
  - active_vld=0, pend_vld=0, idx=0, o_overflow=0.
  - Outputs: o_valid=0, o_data=0, o_index=0, o_last=0, i_ready=1.
  - Buffer contents need not be cleared.
- Output drive:
  - o_valid = active_vld; o_data = active[idx]; o_index = idx; o_last = active_vld && idx==NUM_NODES-1.
  - All are driven from registers only; there is no combinational path from i_valid, din_vec or o_ready to any output.
- i_ready = !pend_vld. A vector is accepted when i_valid && i_ready.
- FSM states:
  - IDLE: !active_vld.
  - STREAM: active_vld && !pend_vld.
  - STREAM_FULL: active_vld && pend_vld.
- IDLE, accept: load active, active_vld=1, idx=0. The first element is on o_valid the next cycle (latency 1).
- STREAM, o_valid && o_ready && !o_last: idx increments.
- o_valid && o_ready && o_last, state after the same edge:
  - pend_vld: pending moves to active, pend_vld=0, idx=0. No bubble; element 0 of the new vector is valid the next cycle.
  - !pend_vld with a simultaneous accept: din_vec loads directly into active, idx=0, no bubble.
  - !pend_vld with no accept: active_vld=0, return to IDLE.
- STREAM, accept without last handshake: load pending, pend_vld=1. i_ready drops the next cycle.
- STREAM_FULL, last handshake: pending moves to active. i_ready is high again the next cycle. A same-cycle i_valid is rejected because i_ready was low in that cycle.
- Rejected vector (i_valid && !i_ready):
  - Dropped; buffers are unchanged.
  - o_overflow sets the next cycle and stays set until reset.
- o_ready low:
  - idx, o_data and o_valid hold. The vector in active must not change while o_valid && !o_ready.
- o_ready high with o_valid low: no effect.
- Reset asserted mid-stream: immediately aborts. Both buffers are invalidated and idx returns to 0; no partial vector resumes.
- Throughput: one element per cycle with o_ready held high; back-to-back vectors stream without gaps.

Optional Feature:
- Macro: LAYER_SERIALIZER_RELU_EN.
- Defined: o_data = (active[idx][DATA_WIDTH-1]) ? 0 : active[idx]. This applies ReLU on the serial path; stored values are unmodified.
- Undefined: o_data = active[idx] unchanged.
- Timing, handshake and all other outputs are identical in both builds.

Test Plan (NUM_NODES=4, DATA_WIDTH=24):
- Reset, then one vector {10,-3,7,2} with o_ready=1 → o_valid on cycles 1..4, o_data 10,-3,7,2, o_index 0..3, o_last only on cycle 4, then o_valid=0.
- Same vector with RELU_EN defined → o_data 10,0,7,2.
- Vector A; vector B on cycle 2 → i_ready low from cycle 3 until A's last handshake. Output is A0..A3 then B0..B3 with no o_valid gap. o_overflow stays 0.
- A streaming, B pending, C pulsed while i_ready=0 → C never appears on output; o_overflow=1 the next cycle and stays 1.
- o_ready toggled 1,0,0,1,… during a stream → o_index and o_data hold while o_ready=0. All 4 elements are delivered in order, none duplicated.
- rst pulsed low at o_index=2 with a pending vector → outputs go to reset values asynchronously. After release, a new vector streams from index 0 and the old data never appears.

Source files
------------

// File: rtl/layer_serializer_if.sv
// Handshake bundle for layer_serializer: parallel vector in, serial stream out.
// master = serializer side, slave = producer/consumer side.
interface layer_serializer_if #(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_NODES  = 20,
  parameter int IDX_WIDTH  = $clog2(NUM_NODES)
);
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] din_vec [NUM_NODES];
  logic                  i_ready;
  logic                  o_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic [IDX_WIDTH-1:0]  o_index;
  logic                  o_last;

  modport master (
    input  i_valid,
    input  din_vec,
    input  o_ready,
    output i_ready,
    output o_valid,
    output o_data,
    output o_index,
    output o_last
  );

  modport slave (
    output i_valid,
    output din_vec,
    output o_ready,
    input  i_ready,
    input  o_valid,
    input  o_data,
    input  o_index,
    input  o_last
  );
endinterface

// File: rtl/layer_serializer.sv
// Parallel-to-serial converter between layers; one pending vector buffer.
// Optional ReLU on the serial output: LAYER_SERIALIZER_RELU_EN.
module layer_serializer #(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_NODES  = 20,
  parameter int IDX_WIDTH  = $clog2(NUM_NODES)
) (
  input  logic          clk,
  input  logic          rst,
  layer_serializer_if.master bus,
  output logic          o_overflow
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    STREAM_FULL
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX =
    IDX_WIDTH'(NUM_NODES - 1);

  state_t state;
  state_t nxt_state;

  logic [IDX_WIDTH-1:0]  idx;
  logic [IDX_WIDTH-1:0]  nxt_idx;
  logic [DATA_WIDTH-1:0] active  [NUM_NODES];
  logic [DATA_WIDTH-1:0] pending [NUM_NODES];
  logic [DATA_WIDTH-1:0] cur;

  logic active_vld;
  logic pend_vld;
  logic is_last;
  logic accept;
  logic reject;
  logic fire;
  logic fire_last;
  logic load_act;
  logic load_pend;
  logic pend_to_act;

  assign active_vld = (state != IDLE);
  assign pend_vld   = (state == STREAM_FULL);
  assign is_last    = (idx == LAST_IDX);
  assign accept     = bus.i_valid && !pend_vld;
  assign reject     = bus.i_valid && pend_vld;
  assign fire       = active_vld && bus.o_ready;
  assign fire_last  = fire && is_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= nxt_state;
      idx   <= nxt_idx;
    end
  end

  always_comb begin
    nxt_state   = state;
    nxt_idx     = idx;
    load_act    = 1'b0;
    load_pend   = 1'b0;
    pend_to_act = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          load_act  = 1'b1;
          nxt_idx   = '0;
          nxt_state = STREAM;
        end
      end
      STREAM: begin
        if (fire_last) begin
          nxt_idx = '0;
          // A same-edge accept refills active with no bubble
          if (accept) begin
            load_act  = 1'b1;
            nxt_state = STREAM;
          end else begin
            nxt_state = IDLE;
          end
        end else begin
          if (fire) begin
            nxt_idx = idx + 1'b1;
          end
          if (accept) begin
            load_pend = 1'b1;
            nxt_state = STREAM_FULL;
          end
        end
      end
      STREAM_FULL: begin
        if (fire_last) begin
          pend_to_act = 1'b1;
          nxt_idx     = '0;
          nxt_state   = STREAM;
        end else if (fire) begin
          nxt_idx = idx + 1'b1;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_idx   = '0;
      end
    endcase
  end

  // Buffers are never cleared; validity lives in the FSM state
  always_ff @(posedge clk) begin
    if (load_act) begin
      active <= bus.din_vec;
    end else if (pend_to_act) begin
      active <= pending;
    end
    if (load_pend) begin
      pending <= bus.din_vec;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_overflow <= 1'b0;
    end else if (reject) begin
      o_overflow <= 1'b1;
    end
  end

  assign cur = active[idx];

  assign bus.i_ready = !pend_vld;
  assign bus.o_valid = active_vld;
  assign bus.o_index = idx;
  assign bus.o_last  = active_vld && is_last;

`ifdef LAYER_SERIALIZER_RELU_EN
  assign bus.o_data =
    (!active_vld || cur[DATA_WIDTH-1]) ? '0 : cur;
`else
  assign bus.o_data = active_vld ? cur : '0;
`endif

endmodule
